// File: rtl/switch_port_rx.sv
// Receive endpoint for one switch output port: registers each packet, filters on PORT_ID,
// buffers accepted packets in a first-word-fall-through FIFO and keeps saturating statistics.
module switch_port_rx #(
  parameter int unsigned PORT_ID    = 0,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sw_valid,
  input  logic [3:0]                    sw_source,
  input  logic [3:0]                    sw_target,
  input  logic [7:0]                    sw_data,
  output logic                          host_valid,
  input  logic                          host_ready,
  output logic [3:0]                    host_source,
  output logic [3:0]                    host_target,
  output logic [7:0]                    host_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              pkt_count,
  output logic [CNT_W-1:0]              drop_count,
  output logic [CNT_W-1:0]              misroute_count,
  input  logic                          clr_stats
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [1:0] PORT_IDX = PORT_ID[1:0];

  // Stage 1: unconditional capture, the switch cannot be stalled
  logic       in_valid_q;
  logic [3:0] in_source_q;
  logic [3:0] in_target_q;
  logic [7:0] in_data_q;

  logic [15:0]            mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [CNT_W-1:0]       pkt_q, pkt_d;
  logic [CNT_W-1:0]       drop_q, drop_d;
  logic [CNT_W-1:0]       mis_q, mis_d;

  logic hit, push_cand, misroute, full, pop, push, drop;

  function automatic logic [CNT_W-1:0] sat_next(input logic [CNT_W-1:0] cnt, input logic inc,
                                                input logic clr);
    if (clr) begin
      return '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      return cnt + CNT_W'(1);
    end
    return cnt;
  endfunction

  always_comb begin
    hit       = in_target_q[PORT_IDX];
    push_cand = in_valid_q && hit;
    misroute  = in_valid_q && !hit;
    full      = (level_q == FULL_LVL);
    pop       = (level_q != '0) && host_ready;
    // A full FIFO can still take a packet when the head leaves in the same cycle
    push      = push_cand && (!full || pop);
    drop      = push_cand && full && !pop;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    pkt_d  = sat_next(pkt_q, pop, clr_stats);
    drop_d = sat_next(drop_q, drop, clr_stats);
    mis_d  = sat_next(mis_q, misroute, clr_stats);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid_q  <= 1'b0;
      in_source_q <= '0;
      in_target_q <= '0;
      in_data_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pkt_q       <= '0;
      drop_q      <= '0;
      mis_q       <= '0;
    end else begin
      in_valid_q  <= sw_valid;
      in_source_q <= sw_source;
      in_target_q <= sw_target;
      in_data_q   <= sw_data;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pkt_q       <= pkt_d;
      drop_q      <= drop_d;
      mis_q       <= mis_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_source_q, in_target_q, in_data_q};
    end
  end

  always_comb begin
    host_valid = (level_q != '0);
    {host_source, host_target, host_data} = host_valid ? mem_q[rd_ptr_q] : 16'h0000;
    fifo_level     = level_q;
    pkt_count      = pkt_q;
    drop_count     = drop_q;
    misroute_count = mis_q;
  end

endmodule

// File: doc/switch_port_rx.md
Name: switch_port_rx

Overview:
- Receive-side endpoint attached to one output port of the 4-port switch.
- The switch output has no backpressure and presents one packet per cycle while its queue is non-empty, so this block must accept every cycle.
- Each packet is filtered against this port's identity, buffered in a small FIFO, and handed to a host with a valid/ready handshake.
- Keeps saturating statistics counters: delivered packets, overflow drops and misrouted packets.

Parameters:
- PORT_ID, 0, index (0-3) of the switch output port this receiver is attached to.
- FIFO_DEPTH, 4, host-side buffer entries; power of 2, at least 2.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- sw_valid  input  1  switch output packet valid
- sw_source  input  4  packet source field (one-hot source port)
- sw_target  input  4  packet target bitmask (multicast allowed)
- sw_data  input  8  packet payload
- host_valid  output  1  host packet available
- host_ready  input  1  host accepts packet
- host_source  output  4  buffered source field
- host_target  output  4  buffered target field
- host_data  output  8  buffered payload
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- pkt_count  output  CNT_W  packets popped by the host
- drop_count  output  CNT_W  packets lost to FIFO overflow
- misroute_count  output  CNT_W  packets whose target bit PORT_ID is 0
- clr_stats  input  1  synchronous clear of all three counters

Behaviour:
- Reset (async assert, sync deassert use): input register invalid; FIFO empty with read/write pointers 0; host_valid=0; host_source, host_target, host_data=0; fifo_level=0; all counters 0.
- Reset asserted mid-operation discards all buffered and in-flight packets immediately.
- Stage 1, input register: every cycle captures {sw_valid, sw_source, sw_target, sw_data}. No ready exists upstream and none is ever applied.
- Stage 2, classify using the registered packet:
  - valid && target[PORT_ID]=0: misroute. Packet is not stored; misroute_count increments.
  - valid && target[PORT_ID]=1: push candidate. The full target mask is stored unmodified.
- Push rule: push if FIFO not full, or full with a pop in the same cycle. Otherwise the packet is dropped and drop_count increments.
- FIFO is first-word-fall-through:
  - host_valid = (level>0).
  - host_* show the head entry; they are 0 when empty.
- Pop: host_valid && host_ready. Pop advances the read pointer and increments pkt_count. host_ready while empty has no effect.
- Level arithmetic:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.
- Latency: packet on sw_valid at edge N is captured at edge N; it is written at edge N+1; host_valid is high after edge N+1 when the FIFO was empty, i.e. 2 cycles.
- Back-to-back: one packet per cycle sustained with no bubbles while host_ready=1.
- Counters saturate at 2^CNT_W-1 and never wrap.
- clr_stats=1 forces all counters to 0 at the next edge. It takes precedence over any increment in that cycle, and that cycle's event is not counted.
- clr_stats does not affect FIFO contents or level.
- sw_source is not checked; it is passed through unchanged.

Test Plan:
- Single packet: PORT_ID=2, sw_valid for 1 cycle with source=4'b0001, target=4'b0100, data=8'hA5, host_ready=1 → host_valid high exactly 2 cycles later for 1 cycle with the same fields; pkt_count=1; level returns to 0.
- Misroute: PORT_ID=2, target=4'b1011, data=8'h3C → host_valid stays 0; misroute_count=1; drop_count=0. Multicast target=4'b0110 → delivered unchanged.
- Overflow: FIFO_DEPTH=4, host_ready=0, 6 back-to-back valid packets with data 0..5 → fifo_level=4; drop_count=2. Raising host_ready yields data 0,1,2,3 in order, then host_valid=0; pkt_count=4.
- Full with simultaneous pop: FIFO full, host_ready=1, continuous input stream → no drops; level stays at 4; output order matches input order across pointer wrap (at least 12 packets).
- Saturation/clear: CNT_W=3, 10 misrouted packets → misroute_count holds at 7. Pulse clr_stats in the same cycle as a misroute → count reads 0 next cycle.
- Reset mid-stream: 3 packets buffered, assert rst_n=0 asynchronously between edges → host_valid, fifo_level and all counters read 0 immediately. After deassertion, a new packet is delivered with 2-cycle latency.
